// File: rtl/sram_bus_pkg.sv
// Shared definitions for the external asynchronous SRAM bus initiator:
// bus widths, default cycle timing and the state encoding.
package sram_bus_pkg;

  localparam int SRAM_ADDR_W = 21;
  localparam int SRAM_DATA_W = 16;

  // Default timing in fabric clock cycles (3 access cycles = 60 ns at 50 MHz)
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_ACCESS_CYC = 3;
  localparam int DEF_HOLD_CYC   = 1;
  localparam int DEF_TURN_CYC   = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_HOLD   = 3'd3,
    ST_TURN   = 3'd4
  } state_e;

  // The phase counter counts down to zero, so a phase of N cycles loads N-1.
  // A zero-length phase never loads the counter; return 0 to keep it defined.
  function automatic logic [3:0] cnt_load(input int cyc);
    return (cyc > 0) ? 4'(cyc - 1) : 4'd0;
  endfunction

endpackage

// File: rtl/sram_bus_initiator.sv
// Single-outstanding request -> timed asynchronous SRAM read/write cycle.
// Every sram_* pin comes straight from a flop; the next pin values are
// derived from the next FSM state so the pins line up with the state.
module sram_bus_initiator
  import sram_bus_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int ACCESS_CYC = DEF_ACCESS_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int TURN_CYC   = DEF_TURN_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i
);

  localparam int         LANE_W    = DATA_W / 2;
  localparam logic [3:0] SETUP_LD  = cnt_load(SETUP_CYC);
  localparam logic [3:0] ACCESS_LD = cnt_load(ACCESS_CYC);
  localparam logic [3:0] HOLD_LD   = cnt_load(HOLD_CYC);
  localparam logic [3:0] TURN_LD   = cnt_load(TURN_CYC);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] sram_a_q, sram_a_d;
  logic              cs_n_q, cs_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              lb_n_q, lb_n_d;
  logic              ub_n_q, ub_n_d;
  logic [DATA_W-1:0] dq_o_q, dq_o_d;
  logic              dq_oe_q, dq_oe_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              accept;
  logic              in_cycle;
  logic              access_last;
  logic [1:0]        lane_en;
  logic [DATA_W-1:0] rdata_masked;

  // Byte lanes follow the latched LB/UB strobes, which are stable during ACCESS
  assign lane_en = {~ub_n_q, ~lb_n_q};

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign rdata_masked[gi*LANE_W +: LANE_W] =
      lane_en[gi] ? sram_dq_i[gi*LANE_W +: LANE_W] : '0;
  end

  // Next-state, phase counter and next pin values
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
    accept  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACCESS;
          cnt_d   = ACCESS_LD;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          if (TURN_CYC > 0) begin
            state_d = ST_TURN;
            cnt_d   = TURN_LD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end
      end
      ST_TURN: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Address, CS and lane strobes are owned by the op from SETUP through HOLD
    in_cycle    = (state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_HOLD);
    access_last = (state_q == ST_ACCESS) && (cnt_q == 4'd0);

    write_d  = accept ? req_write : write_q;
    sram_a_d = accept ? req_addr : sram_a_q;
    dq_o_d   = (accept && req_write) ? req_wdata : dq_o_q;
    cs_n_d   = ~in_cycle;
    lb_n_d   = accept ? ~req_be[0] : (in_cycle ? lb_n_q : 1'b1);
    ub_n_d   = accept ? ~req_be[1] : (in_cycle ? ub_n_q : 1'b1);
    we_n_d   = ~((state_d == ST_ACCESS) && write_d);
    oe_n_d   = ~((state_d == ST_ACCESS) && !write_d);
    dq_oe_d  = in_cycle && write_d;

    // Response lands on the first HOLD cycle; read data is captured on the
    // edge closing the last ACCESS cycle and held until the next read
    rsp_valid_d = access_last;
    rsp_write_d = access_last ? write_q : rsp_write_q;
    rsp_rdata_d = (access_last && !write_q) ? rdata_masked : rsp_rdata_q;
  end

  // State and pin registers; reset drops every strobe without waiting for a clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      sram_a_q    <= '0;
      cs_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      dq_o_q      <= '0;
      dq_oe_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      sram_a_q    <= sram_a_d;
      cs_n_q      <= cs_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      lb_n_q      <= lb_n_d;
      ub_n_q      <= ub_n_d;
      dq_o_q      <= dq_o_d;
      dq_oe_q     <= dq_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign sram_a     = sram_a_q;
  assign sram_cs_n  = cs_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_lb_n  = lb_n_q;
  assign sram_ub_n  = ub_n_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;

endmodule

// File: tb/tb_sram_bus_initiator.sv
// Bench for sram_bus_initiator: default-timing instance plus a second
// instance with SETUP=2 ACCESS=5 HOLD=2 TURN=0 sharing the same stimulus.
module tb_sram_bus_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_write;
  logic [20:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic [15:0] sram_dq_i;

  // default instance outputs
  logic        d_req_ready, d_rsp_valid, d_rsp_write, d_busy;
  logic [15:0] d_rsp_rdata, d_dq_o;
  logic [20:0] d_sram_a;
  logic        d_cs_n, d_oe_n, d_we_n, d_lb_n, d_ub_n, d_dq_oe;
  // sweep instance outputs
  logic        s_req_ready, s_rsp_valid, s_rsp_write, s_busy;
  logic [15:0] s_rsp_rdata, s_dq_o;
  logic [20:0] s_sram_a;
  logic        s_cs_n, s_oe_n, s_we_n, s_lb_n, s_ub_n, s_dq_oe;

  sram_bus_initiator dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(d_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(d_rsp_valid), .rsp_write(d_rsp_write), .rsp_rdata(d_rsp_rdata),
    .busy(d_busy), .sram_a(d_sram_a), .sram_cs_n(d_cs_n), .sram_oe_n(d_oe_n),
    .sram_we_n(d_we_n), .sram_lb_n(d_lb_n), .sram_ub_n(d_ub_n),
    .sram_dq_o(d_dq_o), .sram_dq_oe(d_dq_oe), .sram_dq_i(sram_dq_i)
  );

  sram_bus_initiator #(.SETUP_CYC(2), .ACCESS_CYC(5), .HOLD_CYC(2), .TURN_CYC(0)) dut_sw (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(s_req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(s_rsp_valid), .rsp_write(s_rsp_write), .rsp_rdata(s_rsp_rdata),
    .busy(s_busy), .sram_a(s_sram_a), .sram_cs_n(s_cs_n), .sram_oe_n(s_oe_n),
    .sram_we_n(s_we_n), .sram_lb_n(s_lb_n), .sram_ub_n(s_ub_n),
    .sram_dq_o(s_dq_o), .sram_dq_oe(s_dq_oe), .sram_dq_i(sram_dq_i)
  );

  // Observed instance: sel = 0 default timing, sel = 1 sweep timing
  logic sel;
  logic        m_req_ready, m_rsp_valid, m_rsp_write, m_busy;
  logic [15:0] m_rsp_rdata, m_dq_o;
  logic [20:0] m_sram_a;
  logic        m_cs_n, m_oe_n, m_we_n, m_lb_n, m_ub_n, m_dq_oe;
  assign m_req_ready = sel ? s_req_ready : d_req_ready;
  assign m_rsp_valid = sel ? s_rsp_valid : d_rsp_valid;
  assign m_rsp_write = sel ? s_rsp_write : d_rsp_write;
  assign m_busy      = sel ? s_busy      : d_busy;
  assign m_rsp_rdata = sel ? s_rsp_rdata : d_rsp_rdata;
  assign m_dq_o      = sel ? s_dq_o      : d_dq_o;
  assign m_sram_a    = sel ? s_sram_a    : d_sram_a;
  assign m_cs_n      = sel ? s_cs_n      : d_cs_n;
  assign m_oe_n      = sel ? s_oe_n      : d_oe_n;
  assign m_we_n      = sel ? s_we_n      : d_we_n;
  assign m_lb_n      = sel ? s_lb_n      : d_lb_n;
  assign m_ub_n      = sel ? s_ub_n      : d_ub_n;
  assign m_dq_oe     = sel ? s_dq_oe     : d_dq_oe;

  int checks = 0;
  int failures = 0;
  logic [15:0] prev_rd;   // model of rsp_rdata held since the last read

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Lane rule: a disabled byte lane reads as 0x00
  function automatic logic [15:0] lane_model(input logic [1:0] be, input logic [15:0] d);
    logic [15:0] r;
    r = 16'h0000;
    if (be[0]) r = r | (d & 16'h00FF);
    if (be[1]) r = r | (d & 16'hFF00);
    return r;
  endfunction

  // Bus invariants on the default instance, sampled every falling edge
  logic [20:0] pa;
  logic        pcs = 1'b1, pwe = 1'b1, poe = 1'b1, prst = 1'b0;
  always @(negedge clk) begin
    if (reset && prst) begin
      checks++;
      if (!d_we_n && !d_oe_n) begin
        failures++; $display("FAIL inv_we_oe_overlap: got we_n=0 oe_n=0 expected never both low");
      end
      checks++;
      if (d_dq_oe && !d_oe_n) begin
        failures++; $display("FAIL inv_dq_oe_vs_oe: got dq_oe=1 with oe_n=0 expected dq_oe=0");
      end
      if (d_sram_a != pa) begin
        checks++;
        if (!(pcs && pwe && poe && d_we_n && d_oe_n)) begin
          failures++;
          $display("FAIL inv_addr_change: got strobe low around address change 0x%0h->0x%0h expected all high", pa, d_sram_a);
        end
      end
    end
    pa   <= d_sram_a;
    pcs  <= d_cs_n;
    pwe  <= d_we_n;
    poe  <= d_oe_n;
    prst <= reset;
  end

  // One transaction on the observed instance, checked cycle by cycle against
  // the phase-length arithmetic. Entry and exit on a falling edge with the DUT idle.
  task automatic run_txn(input logic wr, input logic [20:0] a, input logic [15:0] wd,
                         input logic [1:0] be, input logic [15:0] rd,
                         input logic [15:0] exp_rd, input string tag);
    int s, ac, h, t, l, guard;
    logic in_cyc, acc, first_hold;
    s  = sel ? 2 : 1;
    ac = sel ? 5 : 3;
    h  = sel ? 2 : 1;
    t  = sel ? 0 : 1;
    l  = s + ac + h + t;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_be = be;
    guard = 0;
    while (m_req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("%s.accept_wait", tag), 32'(m_req_ready), 32'd1);
    if (m_req_ready !== 1'b1) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    for (int k = 1; k <= l + 1; k++) begin
      in_cyc     = (k <= s + ac + h);
      acc        = (k > s) && (k <= s + ac);
      first_hold = (k == s + ac + 1);
      chk($sformatf("%s.k%0d.cs_n", tag, k),  32'(m_cs_n),  32'(!in_cyc));
      chk($sformatf("%s.k%0d.we_n", tag, k),  32'(m_we_n),  32'(!(acc && wr)));
      chk($sformatf("%s.k%0d.oe_n", tag, k),  32'(m_oe_n),  32'(!(acc && !wr)));
      chk($sformatf("%s.k%0d.lb_n", tag, k),  32'(m_lb_n),  32'(in_cyc ? !be[0] : 1'b1));
      chk($sformatf("%s.k%0d.ub_n", tag, k),  32'(m_ub_n),  32'(in_cyc ? !be[1] : 1'b1));
      chk($sformatf("%s.k%0d.dq_oe", tag, k), 32'(m_dq_oe), 32'(in_cyc && wr));
      if (in_cyc) chk($sformatf("%s.k%0d.sram_a", tag, k), 32'(m_sram_a), 32'(a));
      if (in_cyc && wr) chk($sformatf("%s.k%0d.dq_o", tag, k), 32'(m_dq_o), 32'(wd));
      chk($sformatf("%s.k%0d.rsp_valid", tag, k), 32'(m_rsp_valid), 32'(first_hold));
      if (first_hold) chk($sformatf("%s.k%0d.rsp_write", tag, k), 32'(m_rsp_write), 32'(wr));
      chk($sformatf("%s.k%0d.rsp_rdata", tag, k), 32'(m_rsp_rdata),
          32'((!wr && k > s + ac) ? exp_rd : prev_rd));
      chk($sformatf("%s.k%0d.req_ready", tag, k), 32'(m_req_ready), 32'(k > l));
      chk($sformatf("%s.k%0d.busy", tag, k), 32'(m_busy), 32'(k <= l));
      // Request lines churn while busy; valid is dropped before the idle cycle
      req_valid = (k < l);
      req_write = 1'($urandom);
      req_addr  = 21'($urandom);
      req_wdata = 16'($urandom);
      req_be    = 2'($urandom);
      // Bus data is only meaningful across the edge that ends the last ACCESS cycle
      sram_dq_i = (k == s + ac) ? rd : 16'($urandom);
      @(negedge clk);
    end
    if (!wr) prev_rd = exp_rd;
  endtask

  // Hold valid high and measure edges between two consecutive acceptances
  task automatic measure_gap(input int exp_gap, input string tag);
    int first, second;
    first = -1;
    second = -1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 21'h0F0F0; req_wdata = 16'hC3C3; req_be = 2'b11;
    for (int n = 0; n < 40 && second < 0; n++) begin
      if (m_req_ready) begin
        if (first < 0) first = n;
        else second = n;
      end
      @(negedge clk);
      if (first >= 0) req_addr = 21'h1A2B3;
    end
    req_valid = 1'b0;
    chk($sformatf("%s.second_seen", tag), 32'(second >= 0), 32'd1);
    chk($sformatf("%s.gap", tag), 32'(second - first), 32'(exp_gap));
    for (int n = 0; n < 40 && m_busy; n++) @(negedge clk);
    chk($sformatf("%s.drained", tag), 32'(m_busy), 32'd0);
    @(negedge clk);
  endtask

  typedef struct {
    logic        wr;
    logic [20:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] dqi;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    reset = 1'b0; sel = 1'b0; prev_rd = 16'h0000;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; sram_dq_i = '0;

    vecs[0] = '{1'b1, 21'h0ABCDE, 16'h1234, 2'b11, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 21'h000010, 16'h0000, 2'b11, 16'hBEEF, 16'hBEEF};
    vecs[2] = '{1'b0, 21'h1FFFFF, 16'h0000, 2'b01, 16'hBEEF, 16'h00EF};
    vecs[3] = '{1'b0, 21'h000000, 16'h0000, 2'b10, 16'hBEEF, 16'hBE00};
    vecs[4] = '{1'b0, 21'h12345,  16'h0000, 2'b00, 16'hFFFF, 16'h0000};
    vecs[5] = '{1'b1, 21'h155555, 16'hA5A5, 2'b00, 16'h0000, 16'h0000};
    vecs[6] = '{1'b1, 21'h00AAAA, 16'h5A5A, 2'b01, 16'h0000, 16'h0000};
    vecs[7] = '{1'b0, 21'h0F00F0, 16'h0000, 2'b11, 16'h0001, 16'h0001};

    // Values while reset is held
    @(negedge clk);
    chk("rst.cs_n", 32'(d_cs_n), 32'd1);
    chk("rst.oe_n", 32'(d_oe_n), 32'd1);
    chk("rst.we_n", 32'(d_we_n), 32'd1);
    chk("rst.lb_n", 32'(d_lb_n), 32'd1);
    chk("rst.ub_n", 32'(d_ub_n), 32'd1);
    chk("rst.sram_a", 32'(d_sram_a), 32'd0);
    chk("rst.dq_o", 32'(d_dq_o), 32'd0);
    chk("rst.dq_oe", 32'(d_dq_oe), 32'd0);
    chk("rst.rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("rst.rsp_write", 32'(d_rsp_write), 32'd0);
    chk("rst.rsp_rdata", 32'(d_rsp_rdata), 32'd0);
    chk("rst.busy", 32'(d_busy), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst.req_ready_after_release", 32'(d_req_ready), 32'd1);
    @(negedge clk);

    foreach (vecs[i]) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].dqi,
              vecs[i].exp_rd, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      logic        wr;
      logic [1:0]  be;
      logic [15:0] rd;
      wr = 1'($urandom_range(0, 1));
      be = 2'($urandom);
      rd = 16'($urandom);
      run_txn(wr, 21'($urandom), 16'($urandom), be, rd, lane_model(be, rd), $sformatf("rnd%0d", i));
    end

    measure_gap(7, "b2b_default");

    // Reset during ACCESS of a write
    req_valid = 1'b1; req_write = 1'b1; req_addr = 21'h055555; req_wdata = 16'hAAAA; req_be = 2'b11;
    for (int n = 0; n < 20 && !d_req_ready; n++) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid.we_n_before", 32'(d_we_n), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("rstmid.we_n", 32'(d_we_n), 32'd1);
    chk("rstmid.cs_n", 32'(d_cs_n), 32'd1);
    chk("rstmid.dq_oe", 32'(d_dq_oe), 32'd0);
    chk("rstmid.lb_n", 32'(d_lb_n), 32'd1);
    chk("rstmid.busy", 32'(d_busy), 32'd0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk($sformatf("rstmid.held%0d.rsp_valid", n), 32'(d_rsp_valid), 32'd0);
    end
    reset = 1'b1;
    prev_rd = 16'h0000;
    #1;
    chk("rstmid.req_ready", 32'(d_req_ready), 32'd1);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk($sformatf("rstmid.after%0d.rsp_valid", n), 32'(d_rsp_valid), 32'd0);
    end
    run_txn(1'b0, 21'h000777, 16'h0000, 2'b11, 16'h7E57, 16'h7E57, "rstmid.read");

    // Sweep instance: start both instances from a clean reset
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    prev_rd = 16'h0000;
    sel = 1'b1;
    @(negedge clk);
    run_txn(1'b1, 21'h0ABCDE, 16'h1234, 2'b11, 16'h0000, 16'h0000, "sw.write");
    run_txn(1'b0, 21'h000010, 16'h0000, 2'b10, 16'hBEEF, 16'hBE00, "sw.read");
    measure_gap(10, "b2b_sweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case something stalls the sequence
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected sequence completion");
    $fatal(1, "watchdog");
  end

endmodule
